// File: rtl/operand_serializer.sv
// Bit-serial feeder: captures an operand pair via valid/ready and streams one
// bit pair per clock to a downstream 1-bit sum stage, with stall and done pulse.
module operand_serializer #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             i_hold,
  output logic             o_a,
  output logic             o_b,
  output logic             o_en,
  output logic             o_last,
  output logic [CNT_W-1:0] o_idx,
  output logic             o_done
);
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam int               OUT_BIT  = MSB_FIRST ? WIDTH - 1 : 0;

  state_t           state;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CNT_W-1:0] idx;
  logic             done;

  assign in_ready = (state == IDLE);
  assign o_en     = (state == SHIFT) & ~i_hold;
  assign o_last   = (state == SHIFT) & (idx == LAST_IDX);
  assign o_idx    = idx;
  assign o_done   = done;
  // the presented bit always sits at the output end of the shift register
  assign o_a      = sh_a[OUT_BIT];
  assign o_b      = sh_b[OUT_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a  <= in_a;
            sh_b  <= in_b;
            idx   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!i_hold) begin
            // final bit is not shifted away so idle outputs keep the last pair
            if (idx == LAST_IDX) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              idx  <= idx + CNT_W'(1);
              sh_a <= MSB_FIRST ? (sh_a << 1) : (sh_a >> 1);
              sh_b <= MSB_FIRST ? (sh_b << 1) : (sh_b >> 1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_serializer.sv
// Randomized bench for operand_serializer: three instances (LSB-first, MSB-first,
// WIDTH=1) checked each cycle against a per-instance transaction-level model.
module tb_operand_serializer;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a, in_b;
  logic       i_hold;

  logic [2:0] rdy, oa, ob, en, last, dn;
  logic [3:0] idx0, idx1, idx2;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  operand_serializer #(.WIDTH(8), .CNT_W(4), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(in_a), .in_b(in_b), .i_hold(i_hold),
    .o_a(oa[0]), .o_b(ob[0]), .o_en(en[0]), .o_last(last[0]),
    .o_idx(idx0), .o_done(dn[0]));

  operand_serializer #(.WIDTH(8), .CNT_W(4), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(in_a), .in_b(in_b), .i_hold(i_hold),
    .o_a(oa[1]), .o_b(ob[1]), .o_en(en[1]), .o_last(last[1]),
    .o_idx(idx1), .o_done(dn[1]));

  operand_serializer #(.WIDTH(1), .CNT_W(4), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_a(in_a[0:0]), .in_b(in_b[0:0]), .i_hold(i_hold),
    .o_a(oa[2]), .o_b(ob[2]), .o_en(en[2]), .o_last(last[2]),
    .o_idx(idx2), .o_done(dn[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference: each instance holds a captured operand pair and a count of
  // bits already delivered; the presented bit is looked up by stream position.
  int         mw   [3] = '{8, 8, 1};
  bit         mmsb [3] = '{1'b0, 1'b1, 1'b0};
  bit         busy [3];
  logic [7:0] opa [3], opb [3];
  int         k    [3];
  bit         mdone[3];
  bit         la [3], lb [3];

  function automatic int bitpos(input int i, input int n);
    return mmsb[i] ? mw[i] - 1 - n : n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        busy[i] = 1'b0; k[i] = 0; mdone[i] = 1'b0; la[i] = 1'b0; lb[i] = 1'b0;
      end else begin
        mdone[i] = 1'b0;
        if (!busy[i]) begin
          if (in_valid) begin
            busy[i] = 1'b1;
            opa[i]  = in_a;
            opb[i]  = in_b;
            k[i]    = 0;
            la[i]   = opa[i][bitpos(i, 0)];
            lb[i]   = opb[i][bitpos(i, 0)];
          end
        end else if (!i_hold) begin
          if (k[i] == mw[i] - 1) begin
            busy[i]  = 1'b0;
            mdone[i] = 1'b1;
          end else begin
            k[i]  = k[i] + 1;
            la[i] = opa[i][bitpos(i, k[i])];
            lb[i] = opb[i][bitpos(i, k[i])];
          end
        end
      end
    end
  end

  bit checking = 1'b0;

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        int oidx;
        oidx = (i == 0) ? int'(idx0) : (i == 1) ? int'(idx1) : int'(idx2);
        chk($sformatf("u%0d.in_ready", i), int'(rdy[i]),  int'(!busy[i]));
        chk($sformatf("u%0d.o_en", i),     int'(en[i]),   int'(busy[i] && !i_hold));
        chk($sformatf("u%0d.o_last", i),   int'(last[i]), int'(busy[i] && k[i] == mw[i] - 1));
        chk($sformatf("u%0d.o_done", i),   int'(dn[i]),   int'(mdone[i]));
        chk($sformatf("u%0d.o_idx", i),    oidx,          k[i]);
        chk($sformatf("u%0d.o_a", i),      int'(oa[i]),   int'(la[i]));
        chk($sformatf("u%0d.o_b", i),      int'(ob[i]),   int'(lb[i]));
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] a, input logic [7:0] b,
                       input bit h, input bit r);
    @(negedge clk);
    #1;
    in_valid = v; in_a = a; in_b = b; i_hold = h; rst = r;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; i_hold = 1'b0;
    @(posedge clk);
    @(posedge clk);
    checking = 1'b1;
    // basic A5/3C stream
    drive(1, 8'hA5, 8'h3C, 0, 0);
    drive(0, 8'h00, 8'h00, 0, 0);
    repeat (9) drive(0, 8'h00, 8'h00, 0, 0);
    // stall for 3 cycles at bit 2
    drive(1, 8'hC3, 8'h5A, 0, 0);
    drive(0, 8'h00, 8'h00, 0, 0);
    drive(0, 8'h00, 8'h00, 0, 0);
    repeat (3) drive(0, 8'h00, 8'h00, 1, 0);
    repeat (8) drive(0, 8'h00, 8'h00, 0, 0);
    // reset in the middle of a transfer, then FF/00
    drive(1, 8'h96, 8'h69, 0, 0);
    repeat (4) drive(0, 8'h00, 8'h00, 0, 0);
    drive(0, 8'h00, 8'h00, 0, 1);
    drive(1, 8'hFF, 8'h00, 0, 0);
    repeat (10) drive(0, 8'h00, 8'h00, 0, 0);
    // back-to-back with in_valid held high
    drive(1, 8'h01, 8'h80, 0, 0);
    repeat (9) drive(1, 8'hFE, 8'h7F, 0, 0);
    repeat (10) drive(1, 8'h33, 8'h44, 0, 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end
    drive(0, 8'h00, 8'h00, 0, 0);
    @(negedge clk);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
